// File: rtl/reg_file.sv
// Parametrised register file: one byte-enabled synchronous write port and two
// combinational read ports. Entry 0 can be hardwired to zero, and writes can be forwarded to same-cycle reads.
module reg_file #(
    parameter int                 WIDTH       = 32,
    parameter int                 DEPTH       = 32,
    parameter int                 ZERO_REG    = 1,
    parameter int                 BYPASS      = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    localparam int                AW          = $clog2(DEPTH),
    localparam int                BW          = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             syncClear,
    input  logic             wrEnable,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic [BW-1:0]    wrByteEn,
    input  logic [AW-1:0]    rdAddrA,
    output logic [WIDTH-1:0] rdDataA,
    input  logic [AW-1:0]    rdAddrB,
    output logic [WIDTH-1:0] rdDataB
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             wr_legal;
    logic [WIDTH-1:0] wr_old;
    logic [WIDTH-1:0] wr_merged;
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;
    logic             byp_a;
    logic             byp_b;
    logic             zero_a;
    logic             zero_b;

    assign wr_legal = wrEnable && !syncClear && (int'(wrAddr) < DEPTH) &&
                      !((ZERO_REG != 0) && (wrAddr == '0));

    // Out-of-range addresses match no entry, so their lookups fall back to zero.
    always_comb begin
        wr_old   = '0;
        stored_a = '0;
        stored_b = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (int'(wrAddr) == e)  wr_old   = mem_q[e];
            if (int'(rdAddrA) == e) stored_a = mem_q[e];
            if (int'(rdAddrB) == e) stored_b = mem_q[e];
        end
    end

    always_comb begin
        wr_merged = wr_old;
        for (int i = 0; i < BW; i++) begin
            if (wrByteEn[i]) wr_merged[8*i +: 8] = wrData[8*i +: 8];
        end
    end

    always_comb begin
        mem_d = mem_q;
        for (int e = 0; e < DEPTH; e++) begin
            if (syncClear) begin
                mem_d[e] = RESET_VALUE;
            end else if (wr_legal && (int'(wrAddr) == e)) begin
                mem_d[e] = wr_merged;
            end
        end
    end

    // NOTE: the storage array has an async reset because reset must make
    // every entry read RESET_VALUE immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) mem_q[e] <= RESET_VALUE;
        end else begin
            // NOTE: sequential state is assigned non-blocking only, so every entry updates from pre-edge values.
            mem_q <= mem_d;
        end
    end

    // A write that is pending while rst is high is discarded, so it is never forwarded.
    assign byp_a  = (BYPASS != 0) && wr_legal && !rst && (rdAddrA == wrAddr);
    assign byp_b  = (BYPASS != 0) && wr_legal && !rst && (rdAddrB == wrAddr);
    assign zero_a = (ZERO_REG != 0) && (rdAddrA == '0);
    assign zero_b = (ZERO_REG != 0) && (rdAddrB == '0);

    always_comb begin
        rdDataA = stored_a;
        if (zero_a)     rdDataA = '0;
        else if (byp_a) rdDataA = wr_merged;
    end

    always_comb begin
        rdDataB = stored_b;
        if (zero_b)     rdDataB = '0;
        else if (byp_b) rdDataB = wr_merged;
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: dut0 uses the default parameters; dut1 uses a small,
// non-power-of-two depth with no zero register, no bypass and a nonzero reset value.
module tb_reg_file;

    localparam logic [31:0] RV1 = 32'hCAFEF00D;

    typedef struct {
        int          sel;
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic        clr0, we0;
    logic [4:0]  wa0, ra0, rb0;
    logic [31:0] wd0, da0, db0;
    logic [3:0]  be0;

    logic        clr1, we1;
    logic [3:0]  wa1, ra1, rb1;
    logic [31:0] wd1, da1, db1;
    logic [3:0]  be1;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #50 clk = ~clk;

    reg_file dut0 (
        .clk(clk), .rst(rst), .syncClear(clr0), .wrEnable(we0), .wrAddr(wa0),
        .wrData(wd0), .wrByteEn(be0), .rdAddrA(ra0), .rdDataA(da0),
        .rdAddrB(rb0), .rdDataB(db0)
    );

    reg_file #(.DEPTH(12), .ZERO_REG(0), .BYPASS(0), .RESET_VALUE(RV1)) dut1 (
        .clk(clk), .rst(rst), .syncClear(clr1), .wrEnable(we1), .wrAddr(wa1),
        .wrData(wd1), .wrByteEn(be1), .rdAddrA(ra1), .rdDataA(da1),
        .rdAddrB(rb1), .rdDataB(db1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] port_value(input int sel);
        case (sel)
            0:       return da0;
            1:       return db0;
            2:       return da1;
            default: return db1;
        endcase
    endfunction

    // Monitor: read ports are combinational, so all outputs are sampled mid-cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check(e.name, port_value(e.sel), e.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input string name, input logic [31:0] exp);
        exp_t e;
        e.sel  = sel;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        we0 = 1'b1; wa0 = a; wd0 = d; be0 = be;
    endtask

    task automatic wr1(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        we1 = 1'b1; wa1 = a; wd1 = d; be1 = be;
    endtask

    initial begin : stimulus
        rst  = 1'b1;
        clr0 = 1'b0; we0 = 1'b0; wa0 = '0; wd0 = '0; be0 = '0; ra0 = '0; rb0 = '0;
        clr1 = 1'b0; we1 = 1'b0; wa1 = '0; wd1 = '0; be1 = '0; ra1 = '0; rb1 = '0;
        repeat (2) step();
        rst = 1'b0;

        // Reset state
        ra0 = 5'd3; rb0 = 5'd9; ra1 = 4'd3; rb1 = 4'd0;
        expect_val(0, "rst_a3", 32'h0);
        expect_val(1, "rst_b9", 32'h0);
        expect_val(2, "rst1_a3", RV1);
        expect_val(3, "rst1_b0_nozero", RV1);
        step();

        // Async reset mid-cycle, pending write discarded
        wr0(5'd3, 32'hDEADBEEF, 4'hF); step();
        wr0(5'd9, 32'hDEADBEEF, 4'hF); step();
        we0 = 1'b0;
        expect_val(0, "t1_a3", 32'hDEADBEEF);
        expect_val(1, "t1_b9", 32'hDEADBEEF);
        step();
        rst = 1'b1;
        wr0(5'd3, 32'h12345678, 4'hF);
        expect_val(0, "t1_rst_a3", 32'h0);
        expect_val(1, "t1_rst_b9", 32'h0);
        step();
        rst = 1'b0; we0 = 1'b0;
        expect_val(0, "t1_post_a3", 32'h0);
        expect_val(1, "t1_post_b9", 32'h0);
        step();
        expect_val(0, "t1_hold_a3", 32'h0);
        step();
        wr0(5'd3, 32'h0BADF00D, 4'hF); step();
        we0 = 1'b0;
        expect_val(0, "t1_first_wr", 32'h0BADF00D);
        step();

        // Full write, then hold with write disabled
        wr0(5'd5, 32'hDEADBEEF, 4'hF); step();
        we0 = 1'b0; wd0 = 32'h1; ra0 = 5'd5; rb0 = 5'd5;
        expect_val(0, "t2_a5", 32'hDEADBEEF);
        expect_val(1, "t2_b5", 32'hDEADBEEF);
        step();
        expect_val(0, "t2_hold_a5", 32'hDEADBEEF);
        expect_val(1, "t2_hold_b5", 32'hDEADBEEF);
        step();

        // Byte enables, with the merged word forwarded in the write cycle
        wr0(5'd5, 32'h11223344, 4'b0101);
        expect_val(0, "t3_byp_merge", 32'hDE22BE44);
        step();
        we0 = 1'b0;
        expect_val(0, "t3_a5", 32'hDE22BE44);
        expect_val(1, "t3_b5", 32'hDE22BE44);
        step();
        wr0(5'd5, 32'hFFFFFFFF, 4'h0);
        expect_val(0, "t3_be0_byp", 32'hDE22BE44);
        step();
        we0 = 1'b0;
        expect_val(1, "t3_be0_hold", 32'hDE22BE44);
        step();

        // Entry 0: hardwired zero vs ordinary
        wr0(5'd0, 32'hFFFFFFFF, 4'hF); ra0 = 5'd0;
        wr1(4'd0, 32'hFFFFFFFF, 4'hF); ra1 = 4'd0;
        expect_val(0, "t4_zero_byp", 32'h0);
        expect_val(2, "t4_nz_old", RV1);
        step();
        we0 = 1'b0; we1 = 1'b0;
        expect_val(0, "t4_zero", 32'h0);
        expect_val(2, "t4_nz_new", 32'hFFFFFFFF);
        step();

        // Bypass vs registered visibility, both ports on the write address
        wr1(4'd7, 32'h0, 4'hF); step();
        wr0(5'd7, 32'h000000A5, 4'hF); ra0 = 5'd7; rb0 = 5'd7;
        wr1(4'd7, 32'h000000A5, 4'hF); ra1 = 4'd7; rb1 = 4'd7;
        expect_val(0, "t5_byp_a", 32'hA5);
        expect_val(1, "t5_byp_b", 32'hA5);
        expect_val(2, "t5_nobyp_a_old", 32'h0);
        expect_val(3, "t5_nobyp_b_old", 32'h0);
        step();
        we0 = 1'b0; we1 = 1'b0;
        expect_val(0, "t5_a_after", 32'hA5);
        expect_val(2, "t5_nobyp_a_new", 32'hA5);
        expect_val(3, "t5_nobyp_b_new", 32'hA5);
        step();

        // Synchronous clear beats a same-cycle write
        wr0(5'd1, 32'h11111111, 4'hF); wr1(4'd1, 32'h11111111, 4'hF); step();
        wr0(5'd2, 32'h22222222, 4'hF); wr1(4'd2, 32'h22222222, 4'hF); step();
        wr0(5'd2, 32'h00000099, 4'hF); wr1(4'd2, 32'h00000099, 4'hF);
        clr0 = 1'b1; clr1 = 1'b1;
        ra0 = 5'd1; rb0 = 5'd2; ra1 = 4'd1; rb1 = 4'd2;
        expect_val(0, "t6_pre_a1", 32'h11111111);
        expect_val(1, "t6_pre_b2_nobyp", 32'h22222222);
        expect_val(2, "t6_pre1_a1", 32'h11111111);
        expect_val(3, "t6_pre1_b2", 32'h22222222);
        step();
        we0 = 1'b0; we1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
        expect_val(0, "t6_clr_a1", 32'h0);
        expect_val(1, "t6_clr_b2", 32'h0);
        expect_val(2, "t6_clr1_a1", RV1);
        expect_val(3, "t6_clr1_b2", RV1);
        step();
        ra1 = 4'd13; rb1 = 4'd11; rb0 = 5'd31;
        expect_val(2, "t6_oob_a13", 32'h0);
        expect_val(3, "t6_last_b11", RV1);
        expect_val(1, "t6_last_b31", 32'h0);
        step();

        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
